// File: rtl/spi_byte_master.sv
// Byte-wide SPI master, mode 0, MSB first. One start strobe moves one byte out on sdo
// while the byte arriving on sdi is assembled into dout.
module spi_byte_master #(
    parameter logic       SDO_IDLE = 1'b1,
    parameter logic [7:0] DOUT_RST = 8'hFF
) (
    input  logic       cpu_clock,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    input  logic [1:0] speed,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       sck,
    output logic       sdo,
    input  logic       sdi
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  spd_r, spd_s;
    logic [2:0]  phase_r, phase_s;
    logic [3:0]  edge_r, edge_s;
    logic [7:0]  tx_r, tx_s;
    logic [7:0]  rx_r, rx_s;
    logic [7:0]  dout_r, dout_s;
    logic        rdy_r, rdy_s;
    logic        sck_r, sck_s;
    logic        sdo_r, sdo_s;

    // Last phase count of a half period: H - 1 with H = 2^spd.
    function automatic logic [2:0] half_last(input logic [1:0] spd);
        logic [2:0] last;
        case (spd)
            2'd0:    last = 3'd0;
            2'd1:    last = 3'd1;
            2'd2:    last = 3'd3;
            2'd3:    last = 3'd7;
            default: last = 3'd0;
        endcase
        return last;
    endfunction

    // State and output registers; async reset aborts any transfer in flight.
    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            spd_r   <= 2'd0;
            phase_r <= 3'd0;
            edge_r  <= 4'd0;
            tx_r    <= 8'd0;
            rx_r    <= 8'd0;
            dout_r  <= DOUT_RST;
            rdy_r   <= 1'b1;
            sck_r   <= 1'b0;
            sdo_r   <= SDO_IDLE;
        end else begin
            state_r <= state_s;
            spd_r   <= spd_s;
            phase_r <= phase_s;
            edge_r  <= edge_s;
            tx_r    <= tx_s;
            rx_r    <= rx_s;
            dout_r  <= dout_s;
            rdy_r   <= rdy_s;
            sck_r   <= sck_s;
            sdo_r   <= sdo_s;
        end
    end

    // Next-state logic: accept in IDLE, then toggle sck every H cycles for 16 edges.
    always_comb begin
        state_s = state_r;
        spd_s   = spd_r;
        phase_s = phase_r;
        edge_s  = edge_r;
        tx_s    = tx_r;
        rx_s    = rx_r;
        dout_s  = dout_r;
        rdy_s   = rdy_r;
        sck_s   = sck_r;
        sdo_s   = sdo_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SHIFT;
                    rdy_s   = 1'b0;
                    sck_s   = 1'b0;
                    sdo_s   = din[7];
                    tx_s    = {din[6:0], 1'b0};
                    spd_s   = speed;
                    phase_s = 3'd0;
                    edge_s  = 4'd0;
                end else begin
                    rdy_s = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (phase_r == half_last(spd_r)) begin
                    phase_s = 3'd0;
                    sck_s   = ~sck_r;
                    edge_s  = edge_r + 4'd1;
                    if (!sck_r) begin
                        rx_s = {rx_r[6:0], sdi};
                    end else if (edge_r == 4'd15) begin
                        // Final falling edge: rx already holds all eight bits.
                        state_s = ST_IDLE;
                        rdy_s   = 1'b1;
                        dout_s  = rx_r;
                        sdo_s   = SDO_IDLE;
                        edge_s  = 4'd0;
                    end else begin
                        sdo_s = tx_r[7];
                        tx_s  = {tx_r[6:0], 1'b0};
                    end
                end else begin
                    phase_s = phase_r + 3'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                rdy_s   = 1'b1;
                sck_s   = 1'b0;
                sdo_s   = SDO_IDLE;
            end
        endcase
    end

    assign dout = dout_r;
    assign rdy  = rdy_r;
    assign sck  = sck_r;
    assign sdo  = sdo_r;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed self-checking bench for spi_byte_master: timing, loopback data, ignored
// strobes, back-to-back bytes, speed latching and asynchronous abort.
module tb_spi_byte_master;

    logic       cpu_clock = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] din;
    logic [1:0] speed;
    logic [7:0] dout;
    logic       rdy;
    logic       sck;
    logic       sdo;
    logic       sdi;

    logic       loop_en;
    logic [7:0] pat;
    logic       pat_bit;
    int         rise_cnt = 0;
    int         fall_cnt = 0;
    int         rise_base = 0;
    int         fall_base = 0;
    int         checks = 0;
    int         errors = 0;

    spi_byte_master dut (
        .cpu_clock(cpu_clock),
        .rst_n    (rst_n),
        .start    (start),
        .din      (din),
        .speed    (speed),
        .dout     (dout),
        .rdy      (rdy),
        .sck      (sck),
        .sdo      (sdo),
        .sdi      (sdi)
    );

    always #5 cpu_clock = ~cpu_clock;

    always @(posedge sck) rise_cnt = rise_cnt + 1;
    always @(negedge sck) fall_cnt = fall_cnt + 1;

    // Slave model: present pattern bit i before the i-th rising sck edge.
    always_comb begin
        int idx;
        idx     = rise_cnt - rise_base;
        pat_bit = 1'b0;
        if (idx >= 0 && idx < 8) pat_bit = pat[3'(7 - idx)];
    end

    assign sdi = loop_en ? sdo : pat_bit;

    task automatic tick();
        @(posedge cpu_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] b;
        rst_n   = 1'b0;
        start   = 1'b0;
        din     = 8'h00;
        speed   = 2'd0;
        loop_en = 1'b1;
        pat     = 8'h00;
        tick();
        tick();
        check("reset_rdy", 32'(rdy), 32'd1);
        check("reset_sck", 32'(sck), 32'd0);
        check("reset_sdo", 32'(sdo), 32'd1);
        check("reset_dout", 32'(dout), 32'hFF);
        rst_n = 1'b1;
        tick();

        // speed 00, A5 loopback
        b = 8'hA5;
        din = b; speed = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_accept_rdy", 32'(rdy), 32'd0);
        check("t2_accept_sdo", 32'(sdo), 32'(b[7]));
        check("t2_accept_sck", 32'(sck), 32'd0);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            tick();
            if ((cyc % 2) == 0 && cyc < 16) check("t2_sdo_bit", 32'(sdo), 32'(b[3'(7 - cyc / 2)]));
            check("t2_rdy", 32'(rdy), (cyc == 16) ? 32'd1 : 32'd0);
        end
        check("t2_dout", 32'(dout), 32'hA5);
        check("t2_sdo_idle", 32'(sdo), 32'd1);

        // speed 11, transmit 3C, slave returns C3
        loop_en = 1'b0; pat = 8'hC3; rise_base = rise_cnt;
        din = 8'h3C; speed = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_accept_rdy", 32'(rdy), 32'd0);
        for (int cyc = 1; cyc <= 128; cyc++) begin
            tick();
            check("t3_sck", 32'(sck), 32'((cyc / 8) % 2));
            check("t3_rdy", 32'(rdy), (cyc == 128) ? 32'd1 : 32'd0);
        end
        check("t3_dout", 32'(dout), 32'hC3);

        // asynchronous abort mid-transfer at speed 11
        loop_en = 1'b1;
        din = 8'h00; speed = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) tick();
        check("t1_pre_sck", 32'(sck), 32'd1);
        check("t1_pre_rdy", 32'(rdy), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t1_sck", 32'(sck), 32'd0);
        check("t1_rdy", 32'(rdy), 32'd1);
        check("t1_sdo", 32'(sdo), 32'd1);
        check("t1_dout", 32'(dout), 32'hFF);
        #2;
        rst_n = 1'b1;
        tick();

        // speed 01 with stray strobes at +3 and +10
        rise_base = rise_cnt; fall_base = fall_cnt;
        din = 8'h5A; speed = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            start = (cyc == 3 || cyc == 10);
            din   = 8'h00;
            tick();
            start = 1'b0;
            if (cyc == 31) check("t4_rdy_busy", 32'(rdy), 32'd0);
        end
        check("t4_rdy_done", 32'(rdy), 32'd1);
        check("t4_rises", 32'(rise_cnt - rise_base), 32'd8);
        check("t4_falls", 32'(fall_cnt - fall_base), 32'd8);
        check("t4_dout", 32'(dout), 32'h5A);
        tick();
        check("t4_no_queue", 32'(rdy), 32'd1);

        // back-to-back 01 then FE at speed 00
        din = 8'h01; speed = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) tick();
        check("t5_first_rdy", 32'(rdy), 32'd1);
        check("t5_first_dout", 32'(dout), 32'h01);
        din = 8'hFE; start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_second_rdy", 32'(rdy), 32'd0);
        check("t5_second_sdo", 32'(sdo), 32'd1);
        check("t5_hold_dout", 32'(dout), 32'h01);
        for (int cyc = 1; cyc <= 16; cyc++) tick();
        check("t5_end_rdy", 32'(rdy), 32'd1);
        check("t5_end_dout", 32'(dout), 32'hFE);

        // speed change 00 -> 11 at +4 must not affect current byte
        din = 8'h96; speed = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (cyc == 4) speed = 2'd3;
            tick();
            if (cyc >= 15) check("t6_rdy_h1", 32'(rdy), (cyc == 16) ? 32'd1 : 32'd0);
        end
        check("t6_dout1", 32'(dout), 32'h96);
        din = 8'h69; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) tick();
        check("t6_sck_low7", 32'(sck), 32'd0);
        tick();
        check("t6_sck_rise8", 32'(sck), 32'd1);
        for (int cyc = 9; cyc <= 127; cyc++) tick();
        check("t6_rdy_busy", 32'(rdy), 32'd0);
        tick();
        check("t6_rdy_done", 32'(rdy), 32'd1);
        check("t6_dout2", 32'(dout), 32'h69);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
